wb_dram_arbiter: RTL

//  Single-clock, N-port Wishbone (classic) arbiter and adapter for one LiteDRAM user Wishbone port.

---
 rtl/wb_dram_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/wb_dram_arbiter.sv
// Round-robin arbiter that funnels N classic Wishbone masters onto one
// LiteDRAM user Wishbone port. Byte addresses become DRAM word addresses,
// out-of-range requests are answered with err_o without touching DRAM, and
// a stalled DRAM access is ended with err_o once the timeout expires.
module wb_dram_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int WORD_SIZE      = 256,
    parameter int ADDR_WIDTH     = 25,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            sys_clk,
    input  logic                            rst_n,
    input  logic                            initialized_i,
    input  logic [NUM_PORTS-1:0]            cyc_i,
    input  logic [NUM_PORTS-1:0]            stb_i,
    input  logic [NUM_PORTS-1:0]            we_i,
    input  logic [NUM_PORTS*32-1:0]         addr_i,
    input  logic [NUM_PORTS*WORD_SIZE-1:0]  data_i,
    input  logic [NUM_PORTS*WORD_SIZE/8-1:0] sel_i,
    output logic [WORD_SIZE-1:0]            data_o,
    output logic [NUM_PORTS-1:0]            ack_o,
    output logic [NUM_PORTS-1:0]            err_o,
    output logic                            dram_cyc_o,
    output logic                            dram_stb_o,
    output logic                            dram_we_o,
    output logic [ADDR_WIDTH-1:0]           dram_adr_o,
    output logic [WORD_SIZE-1:0]            dram_dat_w_o,
    output logic [WORD_SIZE/8-1:0]          dram_sel_o,
    input  logic [WORD_SIZE-1:0]            dram_dat_r_i,
    input  logic                            dram_ack_i,
    input  logic                            dram_err_i
);
    localparam int SEL_W = WORD_SIZE / 8;
    localparam int LSB   = $clog2(SEL_W);
    localparam int TOP   = LSB + ADDR_WIDTH;
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [PW-1:0] RR_RESET = PW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, COOL} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           rr_q, rr_d;
    logic [PW-1:0]           gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [WORD_SIZE-1:0]    dat_q, dat_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    dcyc_q, dcyc_d;
    logic                    dwe_q, dwe_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    abort_q, abort_d;
    logic [NUM_PORTS-1:0]    ack_q, ack_d;
    logic [NUM_PORTS-1:0]    err_q, err_d;
    logic [WORD_SIZE-1:0]    rdata_q, rdata_d;

    logic [NUM_PORTS-1:0]    req;
    logic                    gnt_found;
    logic [PW-1:0]           gnt_idx;
    logic [31:0]             addr_sel;
    logic                    oor_sel;
    logic                    tmo_hit;
    logic                    abort_now;
    logic                    dram_done;

    // A port is requesting when both its cycle and strobe are high
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_req
        assign req[gi] = cyc_i[gi] & stb_i[gi];
    end

    // Round-robin search: first requester after the last granted port, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_q;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            if (!gnt_found && req[(int'(rr_q) + i) % NUM_PORTS]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'((int'(rr_q) + i) % NUM_PORTS);
            end
        end
    end

    // Any byte-address bit above the DRAM word range makes the request illegal
    assign addr_sel = addr_i[int'(gnt_idx)*32 +: 32];
    assign oor_sel  = |(addr_sel >> TOP);
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

    // Next-state and registered-output logic for the arbitration FSM
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        dcyc_d    = dcyc_q;
        dwe_d     = dwe_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        ack_d     = '0;
        err_d     = '0;
        rdata_d   = rdata_q;
        abort_now = abort_q | ~cyc_i[gnt_q];
        dram_done = dram_ack_i | dram_err_i | tmo_hit;
        case (state_q)
            IDLE: begin
                if (initialized_i && (|req)) begin
                    rr_d    = gnt_idx;
                    gnt_d   = gnt_idx;
                    adr_d   = ADDR_WIDTH'(addr_sel >> LSB);
                    dat_d   = data_i[int'(gnt_idx)*WORD_SIZE +: WORD_SIZE];
                    sel_d   = sel_i[int'(gnt_idx)*SEL_W +: SEL_W];
                    abort_d = 1'b0;
                    cnt_d   = '0;
                    if (oor_sel) begin
                        err_d[gnt_idx] = 1'b1;
                        state_d        = RESP;
                    end else begin
                        dcyc_d  = 1'b1;
                        dwe_d   = we_i[gnt_idx];
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = cnt_q + 1'b1;
                abort_d = abort_now;
                if (dram_done) begin
                    state_d = RESP;
                    dcyc_d  = 1'b0;
                    dwe_d   = 1'b0;
                    cnt_d   = '0;
                    if (dram_ack_i && !dram_err_i) begin
                        rdata_d = dram_dat_r_i;
                    end
                    // A master that walked away gets no response at all
                    if (!abort_now) begin
                        if (dram_err_i || !dram_ack_i) begin
                            err_d[gnt_q] = 1'b1;
                        end else begin
                            ack_d[gnt_q] = 1'b1;
                        end
                    end
                end
            end
            RESP:    state_d = COOL;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= RR_RESET;
            gnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            dcyc_q  <= 1'b0;
            dwe_q   <= 1'b0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            dcyc_q  <= dcyc_d;
            dwe_q   <= dwe_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign data_o       = rdata_q;
    assign ack_o        = ack_q;
    assign err_o        = err_q;
    assign dram_cyc_o   = dcyc_q;
    assign dram_stb_o   = dcyc_q;
    assign dram_we_o    = dwe_q;
    assign dram_adr_o   = adr_q;
    assign dram_dat_w_o = dat_q;
    assign dram_sel_o   = sel_q;

endmodule
